div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle 32-bit integer divider serving the EX stage's DIV/DIVU instructions. It starts when EX raises `div_sel` and holds it while the pipeline pauses. It computes quotient and remainder by radix-2 restoring division, then pulses `div_valid_o` for one cycle with `{quotient, remainder}` so EX can write LO and HI. It is the responder end of the EX-to-divider handshake.

## Interface
Parameters:
- `DIV_W`, 32: operand width; the result is 2*`DIV_W`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `div_sel`  in  1  request; held high by EX for the whole operation.
- `div_sign`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start.
- `dividend`  in  32  EX operand1; sampled at start.
- `divisor`  in  32  EX operand2; sampled at start.
- `flush`  in  1  pipeline flush (exception/eret); aborts any operation.
- `div_result_o`  out  64  [63:32] quotient (to LO), [31:0] remainder (to HI).
- `div_valid_o`  out  1  one-cycle result strobe.

## Operation
- States:
  - `IDLE`: waiting for a request.
  - `CALC`: one quotient bit per cycle.
  - `DONE`: result strobe.
- `IDLE` to `CALC`: `div_sel & ~flush` and divisor != 0. On this edge the unit latches:
  - `|dividend|` and `|divisor|`, taking two's-complement magnitude only when `div_sign` and the MSB is set;
  - `q_neg = div_sign & (dividend[31] ^ divisor[31])`;
  - `r_neg = div_sign & dividend[31]`;
  - the iteration counter, set to 31.
- Divide-by-zero: `IDLE` goes straight to `DONE`. Quotient is 0xFFFFFFFF and remainder is the raw dividend, regardless of `div_sign`.
- `CALC` step, per cycle:
  - Shift the 64-bit partial remainder left 1.
  - Trial-subtract the divisor from bits [63:32].
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - Decrement the counter. When the counter is 0, go to `DONE`.
- Entering `DONE`: the quotient is negated if `q_neg` and the remainder if `r_neg`, both two's-complement mod 2^32. The result is written to the `div_result_o` register.
- Corner case: 0x80000000 / 0xFFFFFFFF signed gives Q = 0x80000000, R = 0 with no trap. Overflow is EX's concern, not this block's.
- `DONE`: `div_valid_o` = 1 for exactly one cycle, then the unit always returns to `IDLE`. Because of this mandatory `IDLE` cycle, a back-to-back DIV still holding `div_sel` restarts cleanly.
- Abort: `flush`, or `div_sel` low, in `CALC` or `DONE` sends the unit to `IDLE` next cycle.
  - In `DONE`, `div_valid_o` is gated by `div_sel & ~flush`.
  - `div_result_o` keeps its last completed value.
- `div_result_o` changes only on entry to `DONE` and is otherwise stable.

## Timing
- Reset: state `IDLE`, counter 0, `div_result_o` = 0, `div_valid_o` = 0, internal registers 0.
- Reset asserted mid-operation returns the unit to `IDLE` immediately; no strobe.
- Start sampled in cycle 0 (`IDLE`). `CALC` runs cycles 1–32. `DONE` with `div_valid_o` = 1 is cycle 33, and the result is valid in the same cycle.
- Divide-by-zero: `div_valid_o` in cycle 1.
- Early-out (with macro): `div_valid_o` in cycle 1.
- Minimum spacing between two strobes: 34 cycles for full operations.
- `div_valid_o` is registered (a state decode ANDed with `div_sel`). There is no combinational path from `dividend`/`divisor` to any output.

## Configuration
- `DIV_EARLY_OUT_EN`:
  - Defined: in `IDLE`, if `|dividend| < |divisor|` (unsigned compare of magnitudes), go directly to `DONE` with Q = 0 and R = dividend (raw, sign preserved).
  - Undefined: every nonzero-divisor operation takes the full 33-cycle path. Results are identical either way; only latency differs.

## Structure
- Package `div_pkg`:
  - state enum `div_state_t` {`IDLE`, `CALC`, `DONE`};
  - `DIV_ITER` = 32;
  - `DIV_ZERO_Q` = 32'hFFFF_FFFF.
- One sub-module, `div_step`: combinational single iteration (shift, trial subtract, quotient bit), 64-bit remainder in, 64-bit remainder out.
- The top module holds the FSM, counter, operand registers and sign fix-up.

## Test plan
- Unsigned 7 / 2, `div_sel` held: `div_valid_o` high only in cycle 33, with `div_result_o` = {0x00000003, 0x00000001}.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002): result = {0xFFFFFFFD, 0xFFFFFFFF}. Signed 7 / -2: result = {0xFFFFFFFD, 0x00000001}.
- Signed 0x80000000 / 0xFFFFFFFF: result = {0x80000000, 0x00000000}. Unsigned 0xFFFFFFFF / 1: result = {0xFFFFFFFF, 0x00000000}.
- Divisor 0, dividend 0x12345678: `div_valid_o` in cycle 1, result = {0xFFFFFFFF, 0x12345678}.
- `flush` asserted in cycle 10 of a division:
  - no strobe;
  - `IDLE` by cycle 11;
  - a following 100 / 7 yields {0x0000000E, 0x00000002}, 33 cycles after its start.
- Back-to-back 100 / 7 then 9 / 3 with `div_sel` held continuously:
  - strobes at cycles 33 and 67;
  - second result = {0x00000003, 0x00000000}.
- With `DIV_EARLY_OUT_EN`: 3 / 10 strobes in cycle 1 with {0x00000000, 0x00000003}. Without the macro it strobes in cycle 33 with the same value.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  localparam int unsigned DIV_ITER   = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_if.sv
// EX-to-divider handshake: EX is the master, the divider responds as slave.
interface div_if #(
  parameter int unsigned DIV_W = 32
);
  logic               div_sel;
  logic               div_sign;
  logic [DIV_W-1:0]   dividend;
  logic [DIV_W-1:0]   divisor;
  logic               flush;
  logic [2*DIV_W-1:0] div_result_o;
  logic               div_valid_o;

  modport master (
    output div_sel, div_sign, dividend, divisor, flush,
    input  div_result_o, div_valid_o
  );

  modport slave (
    input  div_sel, div_sign, dividend, divisor, flush,
    output div_result_o, div_valid_o
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift, trial subtract, shift in quotient bit.
module div_step #(
  parameter int unsigned DIV_W = 32
) (
  input  logic [2*DIV_W-1:0] rem_i,
  input  logic [DIV_W-1:0]   divisor_i,
  output logic [2*DIV_W-1:0] rem_o
);
  logic [2*DIV_W-1:0] shifted;
  logic [DIV_W:0]     trial;

  always_comb begin
    shifted = {rem_i[2*DIV_W-2:0], 1'b0};
    // Bit shifted out of the top joins the trial so divisors >= 2^(W-1) work.
    trial   = {rem_i[2*DIV_W-1], shifted[2*DIV_W-1:DIV_W]} - {1'b0, divisor_i};
    if (!trial[DIV_W]) begin
      rem_o = {trial[DIV_W-1:0], shifted[DIV_W-1:1], 1'b1};
    end else begin
      rem_o = shifted;
    end
  end
endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit DIV/DIVU unit (radix-2 restoring) for the EX stage.
// Optional macro DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned DIV_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  div_if.slave bus
);
  localparam int unsigned CntW = $clog2(DIV_ITER);

  div_state_t         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0]   divisor_q, divisor_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic [2*DIV_W-1:0] result_q, result_d;

  logic [DIV_W-1:0]   abs_a, abs_b;
  logic [DIV_W-1:0]   quo, rmd;
  logic [2*DIV_W-1:0] step_rem;
  logic               start;

  div_step #(
    .DIV_W(DIV_W)
  ) u_step (
    .rem_i    (rem_q),
    .divisor_i(divisor_q),
    .rem_o    (step_rem)
  );

  always_comb begin
    start = bus.div_sel & ~bus.flush;
    abs_a = (bus.div_sign & bus.dividend[DIV_W-1]) ? -bus.dividend : bus.dividend;
    abs_b = (bus.div_sign & bus.divisor[DIV_W-1])  ? -bus.divisor  : bus.divisor;
    quo   = q_neg_q ? -step_rem[DIV_W-1:0]         : step_rem[DIV_W-1:0];
    rmd   = r_neg_q ? -step_rem[2*DIV_W-1:DIV_W]   : step_rem[2*DIV_W-1:DIV_W];

    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    result_d  = result_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (bus.divisor == '0) begin
            result_d = {DIV_ZERO_Q, bus.dividend};
            state_d  = DONE;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (abs_a < abs_b) begin
            result_d = {{DIV_W{1'b0}}, bus.dividend};
            state_d  = DONE;
          end
`endif
          else begin
            rem_d     = {{DIV_W{1'b0}}, abs_a};
            divisor_d = abs_b;
            q_neg_d   = bus.div_sign & (bus.dividend[DIV_W-1] ^ bus.divisor[DIV_W-1]);
            r_neg_d   = bus.div_sign & bus.dividend[DIV_W-1];
            cnt_d     = CntW'(DIV_ITER - 1);
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        if (!start) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          if (cnt_q == '0) begin
            result_d = {quo, rmd};
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      result_q  <= result_d;
    end
  end

  assign bus.div_result_o = result_q;
  assign bus.div_valid_o  = (state_q == DONE) & start;
endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (latencies follow DIV_EARLY_OUT_EN).
module tb_div_unit;
  import div_pkg::*;

`ifdef DIV_EARLY_OUT_EN
  localparam int EoLat = 1;
`else
  localparam int EoLat = 33;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_if bus ();

  div_unit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start at the next negedge (cycle 0); expect one strobe exactly in cycle lat.
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [63:0] exp, input string tag,
                        input bit hold);
    int first = -1;
    int seen  = 0;
    @(negedge clk);
    bus.div_sel  = 1'b1;
    bus.div_sign = s;
    bus.dividend = a;
    bus.divisor  = b;
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk);
      #1;
      if (bus.div_valid_o) begin
        if (first < 0) first = c;
        seen++;
      end
    end
    check({tag, " latency"}, 64'(first), 64'(lat));
    check({tag, " strobes"}, 64'(seen), 64'd1);
    check({tag, " result"}, bus.div_result_o, exp);
    if (!hold) begin
      @(negedge clk);
      bus.div_sel = 1'b0;
    end
  endtask

  task automatic expect_quiet(input int cycles, input string tag);
    int seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (bus.div_valid_o) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    bus.div_sel  = 1'b0;
    bus.div_sign = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.flush    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset valid", {63'd0, bus.div_valid_o}, 64'd0);
    check("reset result", bus.div_result_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_div(1'b0, 32'd7, 32'd2, 33, {32'd3, 32'd1}, "u7/2", 1'b0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFD, 32'hFFFF_FFFF}, "s-7/2", 1'b0);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'hFFFF_FFFD, 32'd1}, "s7/-2", 1'b0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h8000_0000, 32'd0}, "smin/-1", 1'b0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 33, {32'hFFFF_FFFF, 32'd0}, "umax/1", 1'b0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 33, {32'd1, 32'h7FFF_FFFE}, "ubigdiv", 1'b0);
    do_div(1'b0, 32'h1234_5678, 32'd0, 1, {32'hFFFF_FFFF, 32'h1234_5678}, "udiv0", 1'b0);
    do_div(1'b1, 32'h8000_0000, 32'd0, 1, {32'hFFFF_FFFF, 32'h8000_0000}, "sdiv0", 1'b0);
    do_div(1'b0, 32'd3, 32'd10, EoLat, {32'd0, 32'd3}, "u3/10", 1'b0);
    do_div(1'b1, 32'hFFFF_FFFD, 32'd10, EoLat, {32'd0, 32'hFFFF_FFFD}, "s-3/10", 1'b0);

    // Flush in cycle 10 of a running division.
    @(negedge clk);
    bus.div_sel  = 1'b1;
    bus.div_sign = 1'b0;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    begin
      int seen = 0;
      for (int c = 1; c <= 10; c++) begin
        @(posedge clk);
        #1;
        if (bus.div_valid_o) seen++;
      end
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      if (bus.div_valid_o) seen++;
      check("flush no strobe", 64'(seen), 64'd0);
      check("flush idle", {62'd0, dut.state_q}, {62'd0, IDLE});
    end
    @(negedge clk);
    bus.flush   = 1'b0;
    bus.div_sel = 1'b0;
    expect_quiet(40, "flush quiet");
    do_div(1'b0, 32'd100, 32'd7, 33, {32'd14, 32'd2}, "post-flush 100/7", 1'b0);

    // Back-to-back with div_sel held: strobes in cycles 33 and 67.
    do_div(1'b0, 32'd100, 32'd7, 33, {32'd14, 32'd2}, "b2b first", 1'b1);
    do_div(1'b0, 32'd9, 32'd3, 34, {32'd3, 32'd0}, "b2b second", 1'b0);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    bus.div_sel  = 1'b1;
    bus.dividend = 32'd7;
    bus.divisor  = 32'd2;
    repeat (5) @(posedge clk);
    #2;
    rst_n       = 1'b0;
    bus.div_sel = 1'b0;
    #1;
    check("midreset valid", {63'd0, bus.div_valid_o}, 64'd0);
    check("midreset result", bus.div_result_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_quiet(40, "midreset quiet");
    do_div(1'b0, 32'd7, 32'd2, 33, {32'd3, 32'd1}, "after reset 7/2", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
